// File: rtl/board_mem_arbiter.sv
// Single-port RAM arbiter: CPU > UART mailbox > board scan, with read-return
// routing by owner tag and a once-per-frame 10x10 board copy into the video shadow.
module board_mem_arbiter #(
   parameter int                ADDR_W      = 10,
   parameter logic [ADDR_W-1:0] BOARD_BASE  = 10'h100,
   parameter int                BOARD_CELLS = 100,
   parameter logic [ADDR_W-1:0] UART_ADDR   = 10'h0FF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [31:0]       cpu_rdata,
   input  logic              uart_valid,
   input  logic [7:0]        uart_data,
   output logic              uart_ovf,
   input  logic              frame_start,
   output logic              scan_busy,
   output logic              frame_done,
   output logic              cell_we,
   output logic [6:0]        cell_idx,
   output logic [3:0]        cell_val,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;
   localparam logic [1:0] TAG_NONE = 2'd0, TAG_CPU = 2'd1, TAG_SCAN = 2'd2;

   state_t      state_q, state_d;
   logic [6:0]  cnt_q, cnt_d, idx_q, idx_d;
   logic        pend_q, pend_d, full_q, full_d, ovf_q, ovf_d;
   logic [7:0]  hold_q, hold_d;
   logic [1:0]  tag_q, tag_d;
   logic [3:0]  val_q, val_d;
   logic        cpu_g, uart_g, scan_g;

   // Grants are gated by rst so every output reads 0 while reset is held.
   assign cpu_g  = !rst && cpu_req;
   assign uart_g = !rst && !cpu_req && full_q;
   assign scan_g = !rst && !cpu_req && !full_q && (state_q == S_SCAN);

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_g) begin
         mem_en    = 1'b1;
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (uart_g) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = UART_ADDR;
         mem_wdata = {24'b0, hold_q};
      end else if (scan_g) begin
         mem_en    = 1'b1;
         mem_addr  = BOARD_BASE + ADDR_W'(cnt_q);
      end
   end

   assign cpu_gnt    = cpu_g;
   assign cpu_rvalid = (tag_q == TAG_CPU);
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : 32'd0;
   assign cell_we    = (tag_q == TAG_SCAN);
   assign cell_idx   = idx_q;
   assign cell_val   = cell_we ? mem_rdata[3:0] : val_q;
   assign uart_ovf   = ovf_q;
   assign scan_busy  = (state_q != S_IDLE);
   assign frame_done = (state_q == S_DRAIN);

   always_comb begin
      tag_d  = TAG_NONE;
      if (cpu_g && !cpu_we) tag_d = TAG_CPU;
      else if (scan_g)      tag_d = TAG_SCAN;
      idx_d  = scan_g ? cnt_q : idx_q;
      val_d  = cell_we ? mem_rdata[3:0] : val_q;

      // A byte arriving in the drain cycle refills the slot instead of overflowing.
      full_d = full_q;
      hold_d = hold_q;
      ovf_d  = ovf_q;
      if (uart_valid) begin
         if (!full_q || uart_g) begin
            full_d = 1'b1;
            hold_d = uart_data;
         end else begin
            ovf_d  = 1'b1;
         end
      end else if (uart_g) begin
         full_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      case (state_q)
         S_IDLE: begin
            if (frame_start || pend_q) begin
               state_d = S_SCAN;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end
         end
         S_SCAN: begin
            if (frame_start) pend_d = 1'b1;
            if (scan_g) begin
               cnt_d = cnt_q + 7'd1;
               if (cnt_q == 7'(BOARD_CELLS - 1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (frame_start) pend_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         full_q  <= 1'b0;
         hold_q  <= '0;
         ovf_q   <= 1'b0;
         tag_q   <= TAG_NONE;
         idx_q   <= '0;
         val_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         full_q  <= full_d;
         hold_q  <= hold_d;
         ovf_q   <= ovf_d;
         tag_q   <= tag_d;
         idx_q   <= idx_d;
         val_q   <= val_d;
      end
   end

endmodule
